// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed
// request-to-response latency.
//
// A request is accepted in IDLE, held for LATENCY cycles (the array access
// happens on the last of those edges) and then presented as a response that
// is held stable until the requester takes it.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   req_vld    request valid
//   req_rdy    responder can accept a request (IDLE only, never during reset)
//   req_mtype  0 = load, 1 = store
//   req_len    1 = byte, 2 = half, 0 = word, 3 = illegal
//   req_addr   byte address
//   req_wdata  store data, right-aligned
//   rsp_vld    response valid
//   rsp_rdy    requester accepts response
//   rsp_mtype  echo of the accepted req_mtype
//   rsp_data   load data, right-aligned and zero-extended; 0 for stores/errors
//   rsp_err    access faulted, array not updated
module dmem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_mtype,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic        rsp_mtype,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;

    // Captured request.
    logic        r_mtype;
    logic [1:0]  r_len;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_accept;
    logic        w_access;

    // Operands of the array access. With LATENCY = 1 the access happens on
    // the acceptance edge, so the live request is used instead of the capture.
    logic        w_acc_mtype;
    logic [1:0]  w_acc_len;
    logic [31:0] w_acc_addr;
    logic [31:0] w_acc_wdata;

    logic             w_err;
    logic             w_oor;
    logic [IDX_W-1:0] w_idx;
    logic [4:0]       w_shamt;
    logic [31:0]      w_mask;
    logic [31:0]      w_rd_word;
    logic [31:0]      w_ld_data;
    logic [31:0]      w_wr_word;

    logic [31:0] r_mem [MEM_WORDS];

    assign w_acc_mtype = (LATENCY == 1) ? req_mtype : r_mtype;
    assign w_acc_len   = (LATENCY == 1) ? req_len   : r_len;
    assign w_acc_addr  = (LATENCY == 1) ? req_addr  : r_addr;
    assign w_acc_wdata = (LATENCY == 1) ? req_wdata : r_wdata;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        req_rdy     = 1'b0;
        rsp_vld     = 1'b0;
        case (r_state)
            StIdle: begin
                req_rdy  = !rst;
                w_accept = req_vld && !rst;
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_access    = 1'b1;
                        w_state_nxt = StResp;
                    end else begin
                        w_state_nxt = StWait;
                        w_cnt_nxt   = 3'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                // The edge that takes the counter to zero is the access edge,
                // so the response is visible LATENCY cycles after acceptance.
                if (r_cnt == 3'd1) begin
                    w_access    = 1'b1;
                    w_state_nxt = StResp;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            StResp: begin
                rsp_vld = 1'b1;
                if (rsp_rdy) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mtype <= req_mtype;
            r_len   <= req_len;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Address check and lane steering
    // ------------------------------------------------------------------
    assign w_oor   = (w_acc_addr[31:2] >= 30'(MEM_WORDS));
    assign w_idx   = w_acc_addr[IDX_W+1:2];
    assign w_shamt = {w_acc_addr[1:0], 3'b000};

    always_comb begin
        w_err  = w_oor;
        w_mask = 32'hFFFF_FFFF;
        case (w_acc_len)
            2'd1: begin
                w_mask = 32'h0000_00FF;
            end
            2'd2: begin
                w_mask = 32'h0000_FFFF;
                if (w_acc_addr[0]) begin
                    w_err = 1'b1;
                end
            end
            2'd3: begin
                w_err = 1'b1;
            end
            default: begin
                if (w_acc_addr[1:0] != 2'b00) begin
                    w_err = 1'b1;
                end
            end
        endcase
    end

    assign w_rd_word = r_mem[w_idx];
    assign w_ld_data = (w_rd_word >> w_shamt) & w_mask;
    // Merge the right-aligned store data into its lanes, keeping the others.
    assign w_wr_word = (w_rd_word & ~(w_mask << w_shamt))
                     | ((w_acc_wdata & w_mask) << w_shamt);

    // Array contents are intentionally not reset. A reset on the access edge
    // discards the pending store.
    always_ff @(posedge clk) begin
        if (w_access && !rst && w_acc_mtype && !w_err) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Response registers, held stable throughout RESP
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_mtype <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (w_access) begin
            rsp_mtype <= w_acc_mtype;
            rsp_data  <= (w_err || w_acc_mtype) ? 32'd0 : w_ld_data;
            rsp_err   <= w_err;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: three instances (LATENCY 2, 4 and 1) checked
// every cycle against a byte-addressed transaction model, plus directed
// transactions with literal expected data and latency.
module tb_dmem_responder;

    localparam int unsigned MW = 1024;

    logic        clk;
    logic        rst_s       [3];
    logic        req_vld_s   [3];
    logic        req_rdy_w   [3];
    logic        req_mtype_s [3];
    logic [1:0]  req_len_s   [3];
    logic [31:0] req_addr_s  [3];
    logic [31:0] req_wdata_s [3];
    logic        rsp_vld_w   [3];
    logic        rsp_rdy_s   [3];
    logic        rsp_mtype_w [3];
    logic [31:0] rsp_data_w  [3];
    logic        rsp_err_w   [3];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit started = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .MEM_WORDS(MW),
            .LATENCY  (g == 0 ? 2 : (g == 1 ? 4 : 1))
        ) u_dut (
            .clk      (clk),
            .rst      (rst_s[g]),
            .req_vld  (req_vld_s[g]),
            .req_rdy  (req_rdy_w[g]),
            .req_mtype(req_mtype_s[g]),
            .req_len  (req_len_s[g]),
            .req_addr (req_addr_s[g]),
            .req_wdata(req_wdata_s[g]),
            .rsp_vld  (rsp_vld_w[g]),
            .rsp_rdy  (rsp_rdy_s[g]),
            .rsp_mtype(rsp_mtype_w[g]),
            .rsp_data (rsp_data_w[g]),
            .rsp_err  (rsp_err_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction model: byte-addressed memory, one pending request per DUT
    // ------------------------------------------------------------------
    bit [7:0]  m_byte [3][4*MW];
    bit        m_bval [3][4*MW];
    bit        busy   [3];
    int        age    [3];
    bit        p_mt   [3];
    bit        p_err  [3];
    bit [1:0]  p_ln   [3];
    bit [31:0] p_ad   [3];
    bit [31:0] p_wd   [3];
    bit [31:0] p_data [3];
    bit [31:0] p_mask [3];

    function automatic int nbytes(input bit [1:0] ln);
        return (ln == 2'd1) ? 1 : ((ln == 2'd2) ? 2 : 4);
    endfunction

    function automatic bit f_err(input bit [1:0] ln, input bit [31:0] ad);
        if (ad / 4 >= MW) return 1'b1;
        if (ln == 2'd3) return 1'b1;
        if (ln == 2'd2 && (ad % 2) != 0) return 1'b1;
        if (ln == 2'd0 && (ad % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit [31:0] f_load(input int k, input bit [1:0] ln, input bit [31:0] ad);
        bit [31:0] d = '0;
        for (int i = 0; i < nbytes(ln); i++) d[8*i +: 8] = m_byte[k][int'(ad[11:0]) + i];
        return d;
    endfunction

    function automatic bit [31:0] f_mask(input int k, input bit [1:0] ln, input bit [31:0] ad);
        bit [31:0] m = '0;
        for (int i = 0; i < nbytes(ln); i++)
            if (m_bval[k][int'(ad[11:0]) + i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic mem_write(input int k, input bit [1:0] ln, input bit [31:0] ad,
                             input bit [31:0] wd);
        for (int i = 0; i < nbytes(ln); i++) begin
            m_byte[k][int'(ad[11:0]) + i] <= wd[8*i +: 8];
            m_bval[k][int'(ad[11:0]) + i] <= 1'b1;
        end
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        started <= 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (rst_s[k]) begin
                busy[k] <= 1'b0;
            end else if (!busy[k]) begin
                if (req_vld_s[k]) begin
                    busy[k]  <= 1'b1;
                    age[k]   <= 0;
                    p_mt[k]  <= req_mtype_s[k];
                    p_ln[k]  <= req_len_s[k];
                    p_ad[k]  <= req_addr_s[k];
                    p_wd[k]  <= req_wdata_s[k];
                    p_err[k] <= f_err(req_len_s[k], req_addr_s[k]);
                    if (req_mtype_s[k] || f_err(req_len_s[k], req_addr_s[k])) begin
                        p_data[k] <= '0;
                        p_mask[k] <= '1;
                    end else begin
                        p_data[k] <= f_load(k, req_len_s[k], req_addr_s[k]);
                        p_mask[k] <= f_mask(k, req_len_s[k], req_addr_s[k]);
                    end
                    if (lat_of(k) == 1 && req_mtype_s[k] && !f_err(req_len_s[k], req_addr_s[k]))
                        mem_write(k, req_len_s[k], req_addr_s[k], req_wdata_s[k]);
                end
            end else if (age[k] >= lat_of(k) - 1) begin
                if (rsp_rdy_s[k]) busy[k] <= 1'b0;
            end else begin
                age[k] <= age[k] + 1;
                if (age[k] + 1 == lat_of(k) - 1 && p_mt[k] && !p_err[k])
                    mem_write(k, p_ln[k], p_ad[k], p_wd[k]);
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                bit ev;
                ev = busy[k] && (age[k] >= lat_of(k) - 1);
                chk($sformatf("req_rdy[%0d]", k), 32'(req_rdy_w[k]),
                    32'(!rst_s[k] && !busy[k]));
                chk($sformatf("rsp_vld[%0d]", k), 32'(rsp_vld_w[k]), 32'(ev));
                if (ev) begin
                    chk($sformatf("rsp_mtype[%0d]", k), 32'(rsp_mtype_w[k]), 32'(p_mt[k]));
                    chk($sformatf("rsp_err[%0d]", k), 32'(rsp_err_w[k]), 32'(p_err[k]));
                    if (p_mask[k] != 0)
                        chk($sformatf("rsp_data[%0d]", k), rsp_data_w[k] & p_mask[k],
                            p_data[k] & p_mask[k]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed transaction. Starts and ends just after a falling edge.
    // ------------------------------------------------------------------
    task automatic xact(input int k, input bit mt, input bit [1:0] ln, input bit [31:0] ad,
                        input bit [31:0] wd, input bit [31:0] xd, input bit xe,
                        input int hold, input bit chkd,
                        output bit [31:0] got, output int acc_cyc);
        int n;
        got = '0;
        acc_cyc = 0;
        rsp_rdy_s[k]   = (hold == 0);
        req_vld_s[k]   = 1'b1;
        req_mtype_s[k] = mt;
        req_len_s[k]   = ln;
        req_addr_s[k]  = ad;
        req_wdata_s[k] = wd;
        n = 0;
        while (req_rdy_w[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (req_rdy_w[k] !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_wait[%0d]: got no req_rdy required req_rdy within 20 cycles", k);
            req_vld_s[k] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        // Junk request kept valid while busy; it must be ignored.
        req_mtype_s[k] = ~mt;
        req_len_s[k]   = 2'($urandom_range(0, 3));
        req_addr_s[k]  = $urandom;
        req_wdata_s[k] = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_vld_w[k] !== 1'b1 && n < 20);
        chk($sformatf("latency[%0d]", k), 32'(n), 32'(lat_of(k)));
        if (rsp_vld_w[k] !== 1'b1) begin
            #1;
            req_vld_s[k] = 1'b0;
            rsp_rdy_s[k] = 1'b0;
            return;
        end
        got = rsp_data_w[k];
        if (chkd) chk($sformatf("lit_data[%0d]", k), rsp_data_w[k], xd);
        chk($sformatf("lit_err[%0d]", k), 32'(rsp_err_w[k]), 32'(xe));
        chk($sformatf("lit_mtype[%0d]", k), 32'(rsp_mtype_w[k]), 32'(mt));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                if (i > 0) @(negedge clk);
                chk("hold_vld", 32'(rsp_vld_w[k]), 32'd1);
                if (chkd) chk("hold_data", rsp_data_w[k], xd);
                chk("hold_req_rdy", 32'(req_rdy_w[k]), 32'd0);
            end
            @(posedge clk);
            #1;
            rsp_rdy_s[k] = 1'b1;
            @(negedge clk);
            chk("hold_last_vld", 32'(rsp_vld_w[k]), 32'd1);
        end
        #1;
        req_vld_s[k] = 1'b0;
        @(negedge clk);
        chk($sformatf("post_req_rdy[%0d]", k), 32'(req_rdy_w[k]), 32'd1);
        chk($sformatf("post_rsp_vld[%0d]", k), 32'(rsp_vld_w[k]), 32'd0);
        #1;
        rsp_rdy_s[k] = 1'b0;
    endtask

    initial begin
        bit [31:0] d;
        int a0, a1;
        int vcnt;
        for (int k = 0; k < 3; k++) begin
            rst_s[k]       = 1'b1;
            req_vld_s[k]   = 1'b0;
            req_mtype_s[k] = 1'b0;
            req_len_s[k]   = 2'd0;
            req_addr_s[k]  = '0;
            req_wdata_s[k] = '0;
            rsp_rdy_s[k]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_rdy", 32'(req_rdy_w[0]), 32'd0);
        chk("reset_rsp_vld", 32'(rsp_vld_w[0]), 32'd0);
        chk("reset_rsp_data", rsp_data_w[0], 32'd0);
        chk("reset_rsp_err", 32'(rsp_err_w[0]), 32'd0);
        chk("reset_rsp_mtype", 32'(rsp_mtype_w[0]), 32'd0);
        #1;
        for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
        @(negedge clk);
        chk("first_req_rdy", 32'(req_rdy_w[0]), 32'd1);
        #1;

        // LATENCY = 2: word store/load, sub-word merge, errors, back-pressure.
        xact(0, 1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, 1'b1, d, a0);
        xact(0, 1'b0, 2'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b1, d, a0);
        xact(0, 1'b1, 2'd1, 32'h12, 32'hFFFFFF55, 32'h0, 1'b0, 0, 1'b1, d, a0);
        xact(0, 1'b0, 2'd2, 32'h12, 32'h0, 32'h0000DE55, 1'b0, 0, 1'b1, d, a0);
        xact(0, 1'b0, 2'd1, 32'h13, 32'h0, 32'h000000DE, 1'b0, 0, 1'b1, d, a0);
        xact(0, 1'b0, 2'd0, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0, 0, 1'b1, d, a0);
        xact(0, 1'b0, 2'd2, 32'h11, 32'h0, 32'h0, 1'b1, 0, 1'b1, d, a0);
        xact(0, 1'b1, 2'd0, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1, 0, 1'b1, d, a0);
        xact(0, 1'b0, 2'd3, 32'h10, 32'h0, 32'h0, 1'b1, 0, 1'b1, d, a0);
        xact(0, 1'b1, 2'd3, 32'h10, 32'h0BADF00D, 32'h0, 1'b1, 0, 1'b1, d, a0);
        xact(0, 1'b0, 2'd0, MW * 4, 32'h0, 32'h0, 1'b1, 0, 1'b1, d, a0);
        xact(0, 1'b0, 2'd0, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0, 0, 1'b1, d, a0);
        xact(0, 1'b1, 2'd2, 32'h16, 32'h9999_1234, 32'h0, 1'b0, 0, 1'b1, d, a0);
        xact(0, 1'b0, 2'd2, 32'h16, 32'h0, 32'h00001234, 1'b0, 0, 1'b1, d, a0);
        xact(0, 1'b0, 2'd0, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0, 5, 1'b1, d, a0);

        // LATENCY = 2: reset while the response is held drops it.
        req_vld_s[0] = 1'b1; req_mtype_s[0] = 1'b0; req_len_s[0] = 2'd0;
        req_addr_s[0] = 32'h10;
        @(posedge clk);
        #1;
        req_vld_s[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("resp_before_rst_vld", 32'(rsp_vld_w[0]), 32'd1);
        #1;
        rst_s[0] = 1'b1;
        @(negedge clk);
        #1;
        rst_s[0] = 1'b0;
        @(negedge clk);
        chk("resp_dropped_vld", 32'(rsp_vld_w[0]), 32'd0);
        chk("resp_dropped_req_rdy", 32'(req_rdy_w[0]), 32'd1);
        #1;

        // LATENCY = 4: reset in WAIT discards a store.
        req_vld_s[1] = 1'b1; req_mtype_s[1] = 1'b1; req_len_s[1] = 2'd0;
        req_addr_s[1] = 32'h20; req_wdata_s[1] = 32'h12345678;
        @(posedge clk);
        #1;
        req_vld_s[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_s[1] = 1'b1;
        @(negedge clk);
        chk("wait_rst_req_rdy", 32'(req_rdy_w[1]), 32'd0);
        #1;
        rst_s[1] = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) chk("after_rst_req_rdy", 32'(req_rdy_w[1]), 32'd1);
            if (rsp_vld_w[1] === 1'b1) vcnt++;
        end
        chk("discarded_rsp_vld_count", 32'(vcnt), 32'd0);
        #1;
        xact(1, 1'b0, 2'd0, 32'h20, 32'h0, 32'h0, 1'b0, 0, 1'b0, d, a0);
        n_checks++;
        if (d == 32'h12345678) begin
            n_errors++;
            $display("FAIL discarded_store: got %h required anything but 12345678", d);
        end
        xact(1, 1'b1, 2'd0, 32'h24, 32'hCAFEF00D, 32'h0, 1'b0, 0, 1'b1, d, a0);
        xact(1, 1'b0, 2'd0, 32'h24, 32'h0, 32'hCAFEF00D, 1'b0, 0, 1'b1, d, a0);

        // LATENCY = 1: back-to-back, one acceptance every 2 cycles.
        xact(2, 1'b1, 2'd0, 32'h30, 32'hA5A5A5A5, 32'h0, 1'b0, 0, 1'b1, d, a0);
        xact(2, 1'b0, 2'd0, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0, 0, 1'b1, d, a1);
        chk("l1_spacing_0", 32'(a1 - a0), 32'd2);
        xact(2, 1'b1, 2'd1, 32'h31, 32'h00, 32'h0, 1'b0, 0, 1'b1, d, a0);
        chk("l1_spacing_1", 32'(a0 - a1), 32'd2);
        xact(2, 1'b0, 2'd0, 32'h30, 32'h0, 32'hA5A500A5, 1'b0, 0, 1'b1, d, a1);
        chk("l1_spacing_2", 32'(a1 - a0), 32'd2);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
